// File: rtl/lbi_pkg.sv
// Shared types, constants and helpers for the time-multiplexed LBI matrix engine.
package lbi_pkg;

  localparam int unsigned LFSR_W = 32;
  localparam logic [LFSR_W-1:0] LFSR_MASK = 32'h80200003;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    STORE,
    DONE
  } lbi_state_e;

  // One Galois LFSR step.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_MASK : '0);
  endfunction

  // The all-zero state is a fixed point of the LFSR, so it is remapped to 1.
  function automatic logic [LFSR_W-1:0] seed_fix(input logic [LFSR_W-1:0] s);
    return (s == '0) ? LFSR_W'(1) : s;
  endfunction

  // Number of passes needed to cover all rows with the given lane count.
  function automatic int unsigned lbi_passes(input int unsigned rows, input int unsigned lanes);
    return (rows + lanes - 1) / lanes;
  endfunction

endpackage

// File: rtl/lbi_matrix_tdm_if.sv
// Request/response bus of the LBI matrix engine.
interface lbi_matrix_tdm_if #(
  parameter int unsigned NUM_ROW  = 140,
  parameter int unsigned MSG_BITS = 840,
  parameter int unsigned OUT_W    = 6,
  parameter int unsigned SEED_W   = 32
);
  logic                       in_valid;
  logic                       in_ready;
  logic [2*MSG_BITS-1:0]      msg_in;
  logic                       mode_sub;
  logic [NUM_ROW*SEED_W-1:0]  seed_left_in;
  logic [NUM_ROW*SEED_W-1:0]  seed_right_in;
  logic                       out_valid;
  logic                       out_ready;
  logic [NUM_ROW*OUT_W-1:0]   msg_out;
  logic                       busy;

  modport master (
    output in_valid, msg_in, mode_sub, seed_left_in, seed_right_in, out_ready,
    input  in_ready, out_valid, msg_out, busy
  );

  modport slave (
    input  in_valid, msg_in, mode_sub, seed_left_in, seed_right_in, out_ready,
    output in_ready, out_valid, msg_out, busy
  );
endinterface

// File: rtl/lbi_lane.sv
// One row engine: two LFSRs, two accumulators and the add/sub combine.
module lbi_lane
  import lbi_pkg::*;
#(
  parameter int unsigned OUT_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic [LFSR_W-1:0] seed_l,
  input  logic [LFSR_W-1:0] seed_r,
  input  logic              bit_l,
  input  logic              bit_r,
  input  logic              mode,
  output logic [OUT_W-1:0]  result_c
);

  logic [LFSR_W-1:0] lfsr_l_q, lfsr_r_q;
  logic [LFSR_W-1:0] next_l_c, next_r_c;
  logic [OUT_W-1:0]  acc_l_q, acc_r_q;

  // Next LFSR values; their low bits are the coefficients for this step.
  always_comb begin
    next_l_c = lfsr_next(lfsr_l_q);
    next_r_c = lfsr_next(lfsr_r_q);
  end

  // Seed load, then one coefficient step per message bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_l_q <= '0;
      lfsr_r_q <= '0;
      acc_l_q  <= '0;
      acc_r_q  <= '0;
    end else if (load) begin
      lfsr_l_q <= seed_fix(seed_l);
      lfsr_r_q <= seed_fix(seed_r);
      acc_l_q  <= '0;
      acc_r_q  <= '0;
    end else if (step) begin
      lfsr_l_q <= next_l_c;
      lfsr_r_q <= next_r_c;
      acc_l_q  <= acc_l_q + (bit_l ? next_l_c[OUT_W-1:0] : '0);
      acc_r_q  <= acc_r_q + (bit_r ? next_r_c[OUT_W-1:0] : '0);
    end
  end

  // Combine the two dot products modulo 2^OUT_W.
  always_comb begin
    result_c = mode ? (acc_l_q - acc_r_q) : (acc_l_q + acc_r_q);
  end

endmodule

// File: rtl/lbi_matrix_tdm.sv
// Time-multiplexed LBI matrix engine: LANES row engines cover NUM_ROW rows in PASSES passes.
module lbi_matrix_tdm
  import lbi_pkg::*;
#(
  parameter int unsigned NUM_ROW  = 140,
  parameter int unsigned MSG_BITS = 840,
  parameter int unsigned OUT_W    = 6,
  parameter int unsigned SEED_W   = 32,
  parameter int unsigned LANES    = 14
) (
  input logic             clk,
  input logic             reset,
  lbi_matrix_tdm_if.slave bus
);

  localparam int unsigned PASSES = lbi_passes(NUM_ROW, LANES);
  localparam int unsigned PW     = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam int unsigned JW     = (MSG_BITS > 1) ? $clog2(MSG_BITS) : 1;

  lbi_state_e                state_q, state_d;
  logic [PW-1:0]             pass_q, pass_d;
  logic [JW-1:0]             bit_q, bit_d;
  logic                      accept_c, load_c, step_c, store_c;
  logic [MSG_BITS-1:0]       msg_l_q, msg_r_q;
  logic                      mode_q;
  logic [NUM_ROW*OUT_W-1:0]  msg_out_q;
  logic                      in_ready_q, out_valid_q, busy_q;
  logic [LANES*OUT_W-1:0]    lane_res;

  // State and counter registers; handshake outputs are registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      pass_q      <= '0;
      bit_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pass_q      <= pass_d;
      bit_q       <= bit_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
      busy_q      <= (state_d != IDLE);
    end
  end

  // Next-state, counters and lane controls.
  always_comb begin
    state_d  = state_q;
    pass_d   = pass_q;
    bit_d    = bit_q;
    accept_c = 1'b0;
    load_c   = 1'b0;
    step_c   = 1'b0;
    store_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          accept_c = 1'b1;
          pass_d   = '0;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        load_c  = 1'b1;
        bit_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        step_c = 1'b1;
        if (bit_q == JW'(MSG_BITS - 1)) begin
          bit_d   = '0;
          state_d = STORE;
        end else begin
          bit_d = bit_q + JW'(1);
        end
      end
      STORE: begin
        store_c = 1'b1;
        if (pass_q == PW'(PASSES - 1)) begin
          state_d = DONE;
        end else begin
          pass_d  = pass_q + PW'(1);
          state_d = LOAD;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          pass_d  = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Message and mode capture at accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      msg_l_q <= '0;
      msg_r_q <= '0;
      mode_q  <= 1'b0;
    end else if (accept_c) begin
      msg_l_q <= bus.msg_in[2*MSG_BITS-1:MSG_BITS];
      msg_r_q <= bus.msg_in[MSG_BITS-1:0];
      mode_q  <= bus.mode_sub;
    end
  end

  // Lane k serves row pass*LANES+k; lanes past the last row see a zero seed and are never stored.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [LFSR_W-1:0] seed_l, seed_r;

    // Pick this lane's seeds for the current pass.
    always_comb begin
      seed_l = '0;
      seed_r = '0;
      for (int unsigned r = 0; r < NUM_ROW; r++) begin
        if ((r % LANES) == 32'(k) && pass_q == PW'(r / LANES)) begin
          seed_l = bus.seed_left_in[r*SEED_W +: SEED_W];
          seed_r = bus.seed_right_in[r*SEED_W +: SEED_W];
        end
      end
    end

    lbi_lane #(.OUT_W(OUT_W)) u_lane (
      .clk      (clk),
      .reset    (reset),
      .load     (load_c),
      .step     (step_c),
      .seed_l   (seed_l),
      .seed_r   (seed_r),
      .bit_l    (msg_l_q[bit_q]),
      .bit_r    (msg_r_q[bit_q]),
      .mode     (mode_q),
      .result_c (lane_res[k*OUT_W +: OUT_W])
    );
  end

  // Result bank: each STORE writes the rows belonging to the current pass.
  always_ff @(posedge clk) begin
    if (reset) begin
      msg_out_q <= '0;
    end else if (store_c) begin
      for (int unsigned r = 0; r < NUM_ROW; r++) begin
        if (pass_q == PW'(r / LANES)) begin
          msg_out_q[r*OUT_W +: OUT_W] <= lane_res[(r % LANES)*OUT_W +: OUT_W];
        end
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.msg_out   = msg_out_q;

endmodule

// File: tb/tb_lbi_matrix_tdm.sv
// Directed and randomized bench for lbi_matrix_tdm with a row-by-row reference model.
module tb_lbi_matrix_tdm;

  localparam int unsigned NR  = 5;
  localparam int unsigned MB  = 8;
  localparam int unsigned OW  = 6;
  localparam int unsigned LN  = 2;
  localparam int unsigned LAT = 30;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  lbi_matrix_tdm_if #(.NUM_ROW(NR), .MSG_BITS(MB), .OUT_W(OW), .SEED_W(32)) bus ();

  lbi_matrix_tdm #(.NUM_ROW(NR), .MSG_BITS(MB), .OUT_W(OW), .SEED_W(32), .LANES(LN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Each row: sum of LFSR outputs selected by message bits, per half, combined mod 64.
  function automatic logic [NR*OW-1:0] model(input logic [2*MB-1:0] msg, input logic sub,
                                             input logic [NR*32-1:0] sl, input logic [NR*32-1:0] sr);
    logic [NR*OW-1:0] res;
    res = '0;
    for (int r = 0; r < NR; r++) begin
      int unsigned a, b;
      int dl, dr, v;
      a = sl[r*32 +: 32];
      b = sr[r*32 +: 32];
      if (a == 0) a = 1;
      if (b == 0) b = 1;
      dl = 0;
      dr = 0;
      for (int j = 0; j < MB; j++) begin
        a = (a >> 1) ^ (((a & 1) != 0) ? 32'h80200003 : 32'h0);
        b = (b >> 1) ^ (((b & 1) != 0) ? 32'h80200003 : 32'h0);
        if (msg[MB + j]) dl += int'(a % 64);
        if (msg[j])      dr += int'(b % 64);
      end
      v = sub ? (dl - dr) : (dl + dr);
      res[r*OW +: OW] = OW'(v);
    end
    return res;
  endfunction

  function automatic logic [NR*OW-1:0] rep(input logic [OW-1:0] v);
    logic [NR*OW-1:0] res;
    for (int r = 0; r < NR; r++) res[r*OW +: OW] = v;
    return res;
  endfunction

  function automatic logic [NR*32-1:0] rand_seeds();
    logic [NR*32-1:0] s;
    for (int r = 0; r < NR; r++)
      s[r*32 +: 32] = ($urandom_range(0, 3) == 0) ? 32'h0 : 32'($urandom);
    return s;
  endfunction

  // Present one request and hold in_valid for exactly the accept edge.
  task automatic start(input logic [2*MB-1:0] msg, input logic sub,
                       input logic [NR*32-1:0] sl, input logic [NR*32-1:0] sr);
    bus.msg_in        = msg;
    bus.mode_sub      = sub;
    bus.seed_left_in  = sl;
    bus.seed_right_in = sr;
    bus.in_valid      = 1'b1;
    tick();
    bus.in_valid      = 1'b0;
  endtask

  // Count edges after accept until out_valid; busy must stay high meanwhile.
  task automatic wait_out(input string tag);
    int lat;
    bit busy_ok;
    lat = 0;
    busy_ok = 1'b1;
    while (lat < 100 && !bus.out_valid) begin
      tick();
      lat++;
      if (!bus.busy) busy_ok = 1'b0;
    end
    check({tag, "_latency"}, 64'(lat), 64'(LAT));
    check({tag, "_busy"}, 64'(busy_ok), 64'd1);
  endtask

  // Full transaction with out_ready high: result, then return to IDLE.
  task automatic run(input string tag, input logic [2*MB-1:0] msg, input logic sub,
                     input logic [NR*32-1:0] sl, input logic [NR*32-1:0] sr,
                     input logic [NR*OW-1:0] exp);
    start(msg, sub, sl, sr);
    wait_out(tag);
    check({tag, "_msg_out"}, 64'(bus.msg_out), 64'(exp));
    tick();
    check({tag, "_in_ready_after"}, 64'(bus.in_ready), 64'd1);
    check({tag, "_out_valid_after"}, 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    logic [NR*32-1:0] sl, sr;
    logic [2*MB-1:0]  m1, m2;
    logic             s1, s2;
    logic [NR*OW-1:0] snap, exp;

    reset             = 1'b1;
    bus.in_valid      = 1'b0;
    bus.out_ready     = 1'b1;
    bus.msg_in        = '0;
    bus.mode_sub      = 1'b0;
    bus.seed_left_in  = '0;
    bus.seed_right_in = '0;
    repeat (2) tick();
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_msg_out", 64'(bus.msg_out), 64'd0);
    reset = 1'b0;
    tick();

    // Zero message: every row is zero regardless of seeds.
    sl = rand_seeds();
    sr = rand_seeds();
    run("zero_msg", '0, 1'b0, sl, sr, rep(6'd0));

    // Zero seeds map to 1; first two LFSR outputs have low bits 3 and 2.
    run("left_b0", 16'h0100, 1'b0, '0, '0, rep(6'd3));
    run("left_b1", 16'h0200, 1'b0, '0, '0, rep(6'd2));
    run("left_b01", 16'h0300, 1'b0, '0, '0, rep(6'd5));
    run("right_b0_sub", 16'h0001, 1'b1, '0, '0, rep(6'd61));
    run("both_b0_sub", 16'h0101, 1'b1, '0, '0, rep(6'd0));

    // Randomized requests against the model.
    for (int i = 0; i < 6; i++) begin
      sl = rand_seeds();
      sr = rand_seeds();
      m1 = 16'($urandom);
      s1 = 1'($urandom);
      run($sformatf("rand%0d", i), m1, s1, sl, sr, model(m1, s1, sl, sr));
    end

    // Backpressure: result held, second request ignored until the handshake completes.
    sl = rand_seeds();
    sr = rand_seeds();
    m1 = 16'($urandom);
    s1 = 1'($urandom);
    m2 = 16'($urandom);
    s2 = 1'($urandom);
    bus.out_ready = 1'b0;
    start(m1, s1, sl, sr);
    wait_out("bp1");
    snap = bus.msg_out;
    check("bp1_msg_out", 64'(snap), 64'(model(m1, s1, sl, sr)));
    bus.msg_in   = m2;
    bus.mode_sub = s2;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = (i % 2 == 0);
      tick();
      check($sformatf("bp_hold_msg%0d", i), 64'(bus.msg_out), 64'(snap));
      check($sformatf("bp_hold_in_ready%0d", i), 64'(bus.in_ready), 64'd0);
      check($sformatf("bp_hold_out_valid%0d", i), 64'(bus.out_valid), 64'd1);
    end
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    check("bp_release_in_ready", 64'(bus.in_ready), 64'd1);
    check("bp_release_out_valid", 64'(bus.out_valid), 64'd0);
    check("bp_release_busy", 64'(bus.busy), 64'd0);
    tick();
    bus.in_valid = 1'b0;
    check("bp2_accepted_busy", 64'(bus.busy), 64'd1);
    check("bp2_accepted_in_ready", 64'(bus.in_ready), 64'd0);
    wait_out("bp2");
    check("bp2_msg_out", 64'(bus.msg_out), 64'(model(m2, s2, sl, sr)));
    tick();
    check("bp2_in_ready_after", 64'(bus.in_ready), 64'd1);

    // Reset during pass 1 discards everything.
    sl = rand_seeds();
    sr = rand_seeds();
    start(16'hFFFF, 1'b0, sl, sr);
    repeat (11) tick();
    reset = 1'b1;
    tick();
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_msg_out", 64'(bus.msg_out), 64'd0);
    check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    check("midrst_busy", 64'(bus.busy), 64'd0);
    reset = 1'b0;
    m1 = 16'($urandom);
    s1 = 1'($urandom);
    run("post_rst", m1, s1, sl, sr, model(m1, s1, sl, sr));

    // Seed-to-row mapping including the partial final pass.
    for (int r = 0; r < NR; r++) sl[r*32 +: 32] = (r == NR - 1) ? 32'h0 : 32'h2;
    sr = rand_seeds();
    exp = rep(6'd1);
    exp[(NR-1)*OW +: OW] = 6'd3;
    run("seed_map", 16'h0100, 1'b0, sl, sr, exp);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lbi_matrix_tdm.md
Name: lbi_matrix_tdm

Overview:
- Parametrised, time-multiplexed successor of the 140-row LBI matrix engine.
- Computes each output row r as a mod-2^OUT_W combination of two dot products:
  - left dot = left message half · left PRNG row r.
  - right dot = right message half · right PRNG row r.
  - Result is left+right, or left−right when the subtract mode is selected.
- A configurable number of physical lanes handles all rows over several passes.
- Adds valid/ready handshakes on both sides and output backpressure.

Parameters:
- NUM_ROW, 140: number of output rows.
- MSG_BITS, 840: bits per message half.
- OUT_W, 6: output element width; all arithmetic is mod 2^OUT_W.
- SEED_W, 32: per-row seed width; this is also the LFSR width and is fixed at 32.
- LANES, 14: number of physical row engines. PASSES = ceil(NUM_ROW/LANES).

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  request carries a valid message.
- in_ready  out  1  block can accept a request; high only in IDLE.
- msg_in  in  2*MSG_BITS  message. Left half is bits [2*MSG_BITS-1:MSG_BITS]; right half is bits [MSG_BITS-1:0].
- mode_sub  in  1  0 selects left+right; 1 selects left−right. Sampled at accept.
- seed_left_in  in  NUM_ROW*SEED_W  left seeds; row r is bits [r*SEED_W +: SEED_W]. Must be held stable while busy.
- seed_right_in  in  NUM_ROW*SEED_W  right seeds; same layout and stability rule.
- out_valid  out  1  msg_out is valid.
- out_ready  in  1  consumer accepts msg_out.
- msg_out  out  NUM_ROW*OUT_W  row r is bits [r*OUT_W +: OUT_W].
- busy  out  1  state is not IDLE.

Behaviour:
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, msg_out=0, pass counter=0, bit counter=0.
- Accept occurs on an edge where in_valid && in_ready. At that edge the block latches msg_in and mode_sub and moves to LOAD.
- PRNG, 32-bit Galois LFSR:
  - next(s) = (s>>1) ^ (s[0] ? 32'h80200003 : 0).
  - A seed value of 0 is replaced by 32'h1.
- States:
  - IDLE: in_ready=1. Leaves on accept.
  - LOAD, 1 cycle: lane k loads row p*LANES+k. It loads both LFSRs from their seeds and clears both accumulators. Bit counter j=0. Next state is RUN.
  - RUN, MSG_BITS cycles: in cycle j each LFSR computes n=next(s) and stores s<=n. Let c = n[OUT_W-1:0].
    - accL += msgL[j] ? cL : 0.
    - accR += msgR[j] ? cR : 0.
    - j increments. After j=MSG_BITS-1 the next state is STORE.
  - STORE, 1 cycle: for each valid lane, row = mode ? accL−accR : accL+accR, truncated to OUT_W bits. The result is written to result slot p*LANES+k.
    - Lanes with p*LANES+k ≥ NUM_ROW are idle; their results are discarded.
    - If p==PASSES-1, next state is DONE. Otherwise p++ and next state is LOAD.
  - DONE: out_valid=1 and msg_out is held stable. On out_valid && out_ready, out_valid falls, p=0, and state returns to IDLE. A new accept is possible on the following edge at the earliest.
- Latency: out_valid is first high after exactly PASSES*(MSG_BITS+2) rising edges following the accept edge. With default parameters this is 8420.
- Throughput: one message per PASSES*(MSG_BITS+2)+2 cycles when there is no backpressure.
- Backpressure: out_ready may stay low indefinitely. While it does, msg_out and out_valid are held and in_ready stays 0.
- in_valid outside IDLE is ignored. No queueing is performed.
- Reset mid-operation: on the next edge the block returns to reset values. The partial computation is discarded and no out_valid is produced.
- Row-to-lane mapping: rows are processed in ascending order, lane k handles row p*LANES+k, and msg_out bit order matches the row index.

Decomposition:
- Package lbi_pkg holds:
  - The state enum (IDLE, LOAD, RUN, STORE, DONE).
  - The LFSR_MASK constant 32'h80200003.
  - A function lfsr_next().
  - A PASSES computation helper.
- Sub-module lbi_lane contains two LFSRs, two OUT_W accumulators and the add/sub combine. It has load, step, msg bit L, msg bit R and mode inputs, and is instantiated LANES times.
- The top level holds the FSM, counters, message register and result bank.

Test Plan:
- All bench runs use NUM_ROW=5, LANES=2, MSG_BITS=8, OUT_W=6, so PASSES=3 and latency is 30 edges.
- Zero message, random seeds: all msg_out rows = 0; out_valid at exactly edge 30 after accept; busy high throughout.
- All seeds=0, left bit0=1, rest 0, mode=0: every row = 3. Left bit1 only: every row = 2. Left bits 0 and 1: every row = 5.
- All seeds=0, right bit0=1 only, mode=1: every row = 61. Left bit0 and right bit0 set, mode=1: every row = 0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid, and pulse in_valid during that time.
  - Expected: msg_out stable, in_ready=0, second request not accepted.
  - After out_ready=1: IDLE on the next edge; the second request is accepted on the following edge.
- Reset asserted at edge 12 (during pass 1): next edge gives out_valid=0, msg_out=0, in_ready=1. A new request then completes correctly in 30 edges.
- Seed-to-row mapping: row 4 seed=0, all other rows seed=32'h2, left bit0=1. Expected: row4 = 3, rows 0–3 = 1 (next(2)=1). This checks the partial final pass.
